// File: rtl/tone_mix_pkg.sv
// Shared constants and elaboration-time helpers for the multi-tone generator.
// Builds the quarter-wave sine ROM contents without real-number arithmetic.
package tone_mix_pkg;

  // Peak table amplitude for a signed sample of data_w bits: 2^(data_w-1)-1.
  function automatic longint tm_amp(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  localparam longint TM_AMP_16 = tm_amp(16);

  function automatic int tm_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // pi/2 with 60 fractional bits.
  localparam logic signed [127:0] TM_HALF_PI_Q60 = 128'sh1921FB54442D1846;

  // round(A * sin(pi/2 * k / 2^lut_aw)) by a Q60 Taylor series, good far past 1 LSB.
  function automatic longint tm_sin_entry(input int k, input int lut_aw, input int data_w);
    logic signed [127:0] x, x2, term, sum, prod;
    x    = (TM_HALF_PI_Q60 * 128'(k)) >>> lut_aw;
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 60) / 128'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    prod = 128'(tm_amp(data_w)) * sum + (128'sd1 <<< 59);
    return 64'(prod >>> 60);
  endfunction

endpackage

// File: rtl/tone_mix_gen_lut.sv
// Quarter-wave sine lookup: top two phase bits pick the quadrant, output registered.
module tone_sin_lut
  import tone_mix_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LUT_AW = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LUT_AW+1:0]        phase_i,
  output logic signed [DATA_W-1:0] sin_o
);

  localparam int N = 1 << LUT_AW;

  logic signed [DATA_W-1:0] rom [0:N];

  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam longint ENTRY = tm_sin_entry(k, LUT_AW, DATA_W);
    assign rom[k] = DATA_W'(ENTRY);
  end

  logic [1:0]               quad;
  logic [LUT_AW-1:0]        idx;
  logic [LUT_AW:0]          addr;
  logic signed [DATA_W-1:0] mag, sin_d, sin_q;

  assign quad = phase_i[LUT_AW+1 -: 2];
  assign idx  = phase_i[LUT_AW-1:0];

  // Odd quadrants mirror the table; the upper half negates it.
  always_comb begin
    addr  = quad[0] ? ((LUT_AW+1)'(N) - {1'b0, idx}) : {1'b0, idx};
    mag   = rom[addr];
    sin_d = quad[1] ? -mag : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sin_q <= '0;
    else        sin_q <= sin_d;
  end

  assign sin_o = sin_q;

endmodule

// File: rtl/tone_mix_gen.sv
// Multi-tone phase-accumulator source, mixed, decimated and streamed out.
// Define TONE_MIX_SAT_EN to saturate the tone sum instead of scaling it down.
module tone_mix_gen
  import tone_mix_pkg::*;
#(
  parameter int NUM_TONES = 2,
  parameter int PHASE_W   = 16,
  parameter int DATA_W    = 16,
  parameter int LUT_AW    = 8,
  parameter int DECIM     = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_TONES*PHASE_W-1:0]   phase_inc,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic signed [DATA_W-1:0]       m_tdata,
  output logic                           overrun
);

  localparam int TONE_SH = tm_clog2(NUM_TONES);
  localparam int SUM_W   = DATA_W + TONE_SH;
  localparam int CNT_W   = (DECIM > 1) ? tm_clog2(DECIM) : 1;

  logic [NUM_TONES-1:0][PHASE_W-1:0] acc_q, acc_d;
  logic [NUM_TONES-1:0][DATA_W-1:0]  sin_w;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              strobe, load, drop;
  logic                              s1_valid_q, s2_valid_q, m_tvalid_q, overrun_q;
  logic signed [SUM_W-1:0]           sum;
  logic signed [DATA_W-1:0]          mix_d, s2_data_q, m_tdata_q;

  // The strobed sample is taken from the accumulators before this cycle's step.
  assign strobe = en && (cnt_q == '0);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (en) begin
      for (int t = 0; t < NUM_TONES; t++)
        acc_d[t] = acc_q[t] + phase_inc[t*PHASE_W +: PHASE_W];
      cnt_d = (cnt_q == CNT_W'(DECIM - 1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  for (genvar t = 0; t < NUM_TONES; t++) begin : g_tone
    tone_sin_lut #(.DATA_W(DATA_W), .LUT_AW(LUT_AW)) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .phase_i (acc_q[t][PHASE_W-1 -: LUT_AW+2]),
      .sin_o   (sin_w[t])
    );
  end

`ifdef TONE_MIX_SAT_EN
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    sum = '0;
    for (int t = 0; t < NUM_TONES; t++)
      sum = sum + SUM_W'(signed'(sin_w[t]));
`ifdef TONE_MIX_SAT_EN
    if (sum > SUM_W'(D_MAX))      mix_d = D_MAX;
    else if (sum < SUM_W'(D_MIN)) mix_d = D_MIN;
    else                          mix_d = DATA_W'(sum);
`else
    mix_d = DATA_W'(sum >>> TONE_SH);
`endif
  end

  // Stream handshake: a beat transfers on an edge where m_tvalid and m_tready are
  // both high; m_tvalid/m_tdata never change while valid and not accepted, and a
  // sample arriving into a stalled output is discarded and flagged in overrun.
  assign load = s2_valid_q && (!m_tvalid_q || m_tready);
  assign drop = s2_valid_q && m_tvalid_q && !m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= strobe;
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= mix_d;
      if (load) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s2_data_q;
      end else if (m_tvalid_q && m_tready) begin
        m_tvalid_q <= 1'b0;
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_tone_mix_gen.sv
// Directed bench: a single-tone DECIM=1 instance and a two-tone DECIM=5 instance.
module tb_tone_mix_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic               en1, rdy1, vld1, ovr1;
  logic [15:0]        inc1;
  logic signed [15:0] dat1;

  logic               en2, rdy2, vld2, ovr2;
  logic [31:0]        inc2;
  logic signed [15:0] dat2;

  int errors = 0;
  int checks = 0;

  tone_mix_gen #(.NUM_TONES(1), .PHASE_W(16), .DATA_W(16), .LUT_AW(8), .DECIM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .phase_inc(inc1),
    .m_tvalid(vld1), .m_tready(rdy1), .m_tdata(dat1), .overrun(ovr1)
  );

  tone_mix_gen #(.NUM_TONES(2), .PHASE_W(16), .DATA_W(16), .LUT_AW(8), .DECIM(5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .phase_inc(inc2),
    .m_tvalid(vld2), .m_tready(rdy2), .m_tdata(dat2), .overrun(ovr2)
  );

  // Reference sine at a 16-bit phase, rounded half away from zero.
  function automatic int sin_ref(input int phase);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(phase) / 65536.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int mix_ref(input int a, input int b);
    int s;
    s = a + b;
`ifdef TONE_MIX_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    return s >>> 1;
`endif
  endfunction

  // Leaves the bench on the negedge where reset is released (cycle 0).
  task automatic do_reset();
    en1 = 1'b0; rdy1 = 1'b1; inc1 = '0;
    en2 = 1'b0; rdy2 = 1'b1; inc2 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en1 = 1'b0; rdy1 = 1'b1; inc1 = '0;
    en2 = 1'b0; rdy2 = 1'b1; inc2 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    checks += 6;
    if (vld1 !== 1'b0) begin errors++; $display("FAIL reset_vld1 got %b expected 0", vld1); end
    if (dat1 !== 16'sd0) begin errors++; $display("FAIL reset_dat1 got %0d expected 0", dat1); end
    if (ovr1 !== 1'b0) begin errors++; $display("FAIL reset_ovr1 got %b expected 0", ovr1); end
    if (vld2 !== 1'b0) begin errors++; $display("FAIL reset_vld2 got %b expected 0", vld2); end
    if (dat2 !== 16'sd0) begin errors++; $display("FAIL reset_dat2 got %0d expected 0", dat2); end
    if (ovr2 !== 1'b0) begin errors++; $display("FAIL reset_ovr2 got %b expected 0", ovr2); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_tone();
    int pat [4];
    pat = '{0, 32767, 0, -32767};
    do_reset();
    inc1 = 16'h4000; rdy1 = 1'b1; en1 = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 3) begin
        checks++;
        if (vld1 !== 1'b0) begin errors++; $display("FAIL single_latency c=%0d got %b expected 0", c, vld1); end
      end else if (c <= 10) begin
        checks += 3;
        if (vld1 !== 1'b1) begin errors++; $display("FAIL single_vld c=%0d got %b expected 1", c, vld1); end
        if (dat1 !== 16'(pat[(c-3)%4])) begin errors++; $display("FAIL single_data c=%0d got %0d expected %0d", c, dat1, pat[(c-3)%4]); end
        if (ovr1 !== 1'b0) begin errors++; $display("FAIL single_ovr c=%0d got %b expected 0", c, ovr1); end
      end else if (c == 11) begin
        checks += 3;
        if (ovr1 !== 1'b1) begin errors++; $display("FAIL decim1_overrun got %b expected 1", ovr1); end
        if (vld1 !== 1'b1) begin errors++; $display("FAIL decim1_hold_vld got %b expected 1", vld1); end
        if (dat1 !== 16'(pat[3])) begin errors++; $display("FAIL decim1_hold_data got %0d expected %0d", dat1, pat[3]); end
      end else begin
        checks += 2;
        if (vld1 !== 1'b1) begin errors++; $display("FAIL decim1_reload_vld got %b expected 1", vld1); end
        if (dat1 !== 16'(pat[1])) begin errors++; $display("FAIL decim1_reload_data got %0d expected %0d", dat1, pat[1]); end
      end
      rdy1 = (c != 10);
    end
    en1 = 1'b0;
  endtask

  task automatic test_two_tone();
    int q [4];
`ifdef TONE_MIX_SAT_EN
    q = '{0, 32767, 0, -32768};
`else
    q = '{0, 32767, 0, -32767};
`endif
    do_reset();
    inc2 = {16'h4000, 16'h4000}; rdy2 = 1'b1; en2 = 1'b1;
    for (int c = 0; c <= 38; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (c >= 3 && (c - 3) % 5 == 0) begin
        if (vld2 !== 1'b1) begin errors++; $display("FAIL two_tone_vld c=%0d got %b expected 1", c, vld2); end
        checks++;
        if (dat2 !== 16'(q[((c-3)/5)%4])) begin errors++; $display("FAIL two_tone_data c=%0d got %0d expected %0d", c, dat2, q[((c-3)/5)%4]); end
      end else begin
        if (vld2 !== 1'b0) begin errors++; $display("FAIL two_tone_gap c=%0d got %b expected 0", c, vld2); end
      end
    end
    en2 = 1'b0;
  endtask

  task automatic test_sweep_wrap();
    int p, e;
    do_reset();
    inc2 = {16'h0100, 16'h0100}; rdy2 = 1'b1; en2 = 1'b1;
    for (int c = 0; c <= 3 + 5 * 55; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (c >= 3 && (c - 3) % 5 == 0) begin
        p = (((c - 3) / 5) * 32'h0500) & 32'hFFFF;
        e = mix_ref(sin_ref(p), sin_ref(p));
        if (vld2 !== 1'b1) begin errors++; $display("FAIL sweep_vld c=%0d got %b expected 1", c, vld2); end
        checks++;
        if (dat2 !== 16'(e)) begin errors++; $display("FAIL sweep_data phase=%04h got %0d expected %0d", p, dat2, e); end
      end else begin
        if (vld2 !== 1'b0) begin errors++; $display("FAIL sweep_gap c=%0d got %b expected 0", c, vld2); end
      end
    end
    checks++;
    if (ovr2 !== 1'b0) begin errors++; $display("FAIL sweep_overrun got %b expected 0", ovr2); end
    en2 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic ev;
    int   e;
    do_reset();
    inc2 = {16'h0100, 16'h0100}; en2 = 1'b1; rdy2 = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      ev = (c >= 3 && c <= 15) || c == 18 || c == 23;
      e  = (c == 18) ? mix_ref(sin_ref(16'h0F00), sin_ref(16'h0F00)) :
           (c == 23) ? mix_ref(sin_ref(16'h1400), sin_ref(16'h1400)) : 0;
      checks += 2;
      if (vld2 !== ev) begin errors++; $display("FAIL bp_vld c=%0d got %b expected %b", c, vld2, ev); end
      if (ovr2 !== (c >= 8)) begin errors++; $display("FAIL bp_overrun c=%0d got %b expected %b", c, ovr2, (c >= 8)); end
      if (ev) begin
        checks++;
        if (dat2 !== 16'(e)) begin errors++; $display("FAIL bp_data c=%0d got %0d expected %0d", c, dat2, e); end
      end
      rdy2 = (c < 3) || (c >= 15);
    end
    en2 = 1'b0;
  endtask

  task automatic test_en_pause();
    logic ev;
    int   e;
    do_reset();
    inc2 = {16'h0100, 16'h0100}; en2 = 1'b1; rdy2 = 1'b1;
    for (int c = 0; c <= 31; c++) begin
      if (c > 0) @(negedge clk);
      ev = (c == 3) || (c == 8) || (c == 13) || (c == 25) || (c == 30);
      case (c)
        8:       e = mix_ref(sin_ref(16'h0500), sin_ref(16'h0500));
        13:      e = mix_ref(sin_ref(16'h0A00), sin_ref(16'h0A00));
        25:      e = mix_ref(sin_ref(16'h0F00), sin_ref(16'h0F00));
        30:      e = mix_ref(sin_ref(16'h1400), sin_ref(16'h1400));
        default: e = 0;
      endcase
      checks++;
      if (vld2 !== ev) begin errors++; $display("FAIL pause_vld c=%0d got %b expected %b", c, vld2, ev); end
      if (ev) begin
        checks++;
        if (dat2 !== 16'(e)) begin errors++; $display("FAIL pause_data c=%0d got %0d expected %0d", c, dat2, e); end
      end
      en2 = (c < 11) || (c > 17);
    end
    en2 = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int e;
    e = mix_ref(sin_ref(16'h0500), sin_ref(16'h0500));
    do_reset();
    inc2 = {16'h0100, 16'h0100}; en2 = 1'b1; rdy2 = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      rdy2 = (c < 8);
    end
    checks += 3;
    if (vld2 !== 1'b1) begin errors++; $display("FAIL midrun_pre_vld got %b expected 1", vld2); end
    if (dat2 !== 16'(e)) begin errors++; $display("FAIL midrun_pre_data got %0d expected %0d", dat2, e); end
    if (ovr2 !== 1'b1) begin errors++; $display("FAIL midrun_pre_overrun got %b expected 1", ovr2); end
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (vld2 !== 1'b0) begin errors++; $display("FAIL midrun_rst_vld got %b expected 0", vld2); end
    if (dat2 !== 16'sd0) begin errors++; $display("FAIL midrun_rst_data got %0d expected 0", dat2); end
    if (ovr2 !== 1'b0) begin errors++; $display("FAIL midrun_rst_overrun got %b expected 0", ovr2); end
    @(negedge clk);
    rst_n = 1'b1; en2 = 1'b1; rdy2 = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (vld2 !== (c == 3)) begin errors++; $display("FAIL midrun_after_vld c=%0d got %b expected %b", c, vld2, (c == 3)); end
    end
    checks++;
    if (dat2 !== 16'sd0) begin errors++; $display("FAIL midrun_first_sample got %0d expected 0", dat2); end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_two_tone();
    test_sweep_wrap();
    test_backpressure();
    test_en_pause();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_mix_gen.md
# tone_mix_gen

Parametrised multi-tone test-signal source for the FIR filter chain. It generalises the fixed two-tone stimulus to NUM_TONES phase-accumulator oscillators with runtime frequency words and an internal quarter-wave sine table. Each tone is mixed down to one signed sample stream, decimated to the FIR sample rate, and delivered on a valid/ready handshake with overrun detection. It is synthesizable and drives the FIR `noisy_signal` input on hardware as well as in simulation.

## Interface
- NUM_TONES, 2, number of oscillators; must be a power of two, 1..8
- PHASE_W, 16, phase accumulator width; full scale 2^PHASE_W = 2π
- DATA_W, 16, sample width, signed
- LUT_AW, 8, quarter-wave table address bits; PHASE_W ≥ LUT_AW+2
- DECIM, 5, accumulator steps per output sample; ≥1
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance accumulators and decimation counter
- phase_inc  in  NUM_TONES*PHASE_W  unsigned per-tone increment; tone i uses slice i
- m_tvalid  out  1  output sample valid
- m_tready  in  1  downstream accepts
- m_tdata  out  DATA_W  signed mixed sample
- overrun  out  1  sticky: a sample was dropped under backpressure

## Operation
- Reset: all accumulators 0, decimation counter 0, pipeline valids 0, m_tvalid 0, m_tdata 0, overrun 0.
- Accumulators update each cycle with en=1: acc_i <= acc_i + inc_i mod 2^PHASE_W. Wrap-around is natural binary overflow, with no compare/subtract. phase_inc is sampled every cycle, so a change applies at the next step.
- Decimation counter runs 0..DECIM-1 and advances with en. Strobe fires in an en cycle with counter==0. The strobed sample uses the accumulator values *before* that cycle's update.
- Stage 1 (LUT): per tone, sin(acc_i) from the top LUT_AW+2 phase bits; register value and valid.
  - Quadrant 0: table[idx]. Quadrant 1: table[2^LUT_AW − idx]. Quadrant 2: −table[idx]. Quadrant 3: −table[2^LUT_AW − idx].
  - The table has 2^LUT_AW+1 entries: table[k] = round(A·sin(π/2·k/2^LUT_AW)), A = 2^(DATA_W−1)−1.
- Stage 2 (mix): sum all tones at width DATA_W+log2(NUM_TONES). Reduce per Configuration. Register value and valid.
- Output register: loads stage-2 data when stage-2 valid and (m_tvalid=0 or m_tready=1).
  - If stage-2 valid and m_tvalid=1 and m_tready=0, the new sample is dropped, overrun <= 1, and m_tdata/m_tvalid hold.
- m_tvalid clears on a handshake (m_tvalid & m_tready) with no simultaneous load. A simultaneous handshake and load keeps m_tvalid=1 with the new data.
- en=0 freezes accumulators and counter. Samples already in the pipeline still drain.
- Asserting rst_n low mid-operation discards all in-flight samples immediately.

## Timing
- Latency is 3 cycles: strobe in cycle k gives m_tvalid/m_tdata in cycle k+3, given the output is free.
- With continuous en, the sample rate is one per DECIM cycles. With DECIM=1 there is one per cycle, and any m_tready=0 cycle while a new sample arrives sets overrun.
- A held output stays stable until accepted; no combinational path exists from m_tready to m_tvalid.
- overrun is cleared only by reset.

## Configuration
- TONE_MIX_SAT_EN defined: result = sum saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. No scaling, full per-tone amplitude.
- Not defined: result = sum >>> log2(NUM_TONES), an arithmetic shift with floor rounding. It never overflows.

## Structure
- Package tone_mix_pkg holds: amplitude constant A, log2 helper function, and the table-generation function used to initialise the ROM.
- One sub-module, tone_sin_lut: phase in, registered signed sine out. It contains the quadrant logic and the ROM, with one instance per tone.

## Test plan
- Reset mid-run with m_tvalid=1 -> in the same cycle m_tvalid=0, m_tdata=0, overrun=0. After release, the first sample is 0.
- NUM_TONES=1, DECIM=1, inc=0x4000, m_tready=1, en rises at cycle 0 -> m_tvalid from cycle 3, data 0, 32767, 0, −32767 repeating.
- NUM_TONES=2, both inc=0x4000, no macro -> 0, 32767, 0, −32767. With TONE_MIX_SAT_EN -> 0, 32767, 0, −32768.
- DECIM=5, inc=0x0100 -> m_tvalid every 5 cycles; successive samples are table values at phase steps of 0x0500. Wrap from 0xFF00 to 0x0000 gives no glitch.
- DECIM=5, m_tready=0 for 12 cycles after first valid -> first sample held unchanged, the next two dropped, overrun=1 from the first drop. Raising m_tready resumes the stream.
- en low for 7 cycles mid-stream -> in-flight samples drain with no new samples. Resumed samples continue the phase without skipping steps.
